relobi_tmr_r_splitter: RTL and testbench
========================================

# relobi_tmr_r_splitter

Response-side counterpart of the relOBI TMR request voter. It accepts the single R channel returned by a subordinate and fans each response out to three lock-stepped manager replicas. Each response is held until every replica has completed its own rvalid/rready handshake. A bounded skew timeout drops a response that a lagging replica never takes and reports which replicas lagged. It sits between the voted request path's subordinate and the three replicated manager ports of a TMR core.

## Interface
- `ObiCfg`, default `obi_pkg::ObiDefaultConfig`: OBI configuration; carried through for channel typing only.
- `obi_r_chan_t`, default `logic`: relOBI R channel struct (rdata+ECC, rid, err, r_optional, other_ecc); passed through opaquely.
- `Depth`, default 2: response buffer entries; must be ≥ 1.
- `TimeoutCycles`, default 16: stall cycles tolerated on a partially delivered head entry; 0 disables the timeout.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `r_i` in `$bits(obi_r_chan_t)`: response from subordinate.
- `rvalid_i` in 1: response valid.
- `rready_o` out 1: buffer can accept.
- `three_r_o` out 3×`obi_r_chan_t`: per-replica response; all three carry the head entry.
- `three_rvalid_o` out 3: per-replica valid.
- `three_rready_i` in 3: per-replica ready.
- `fault_o` out 1: one-cycle pulse, head entry dropped by timeout.
- `fault_mask_o` out 3: replicas that had not accepted the dropped entry; valid while `fault_o`=1, otherwise 0.

## Operation
- The buffer is a circular FIFO of `Depth` entries. Each entry holds the response and a 3-bit pending mask.
- Push: `rvalid_i && rready_o` writes `r_i` at the tail with mask 3'b111.
- `rready_o = !full`. It depends on registered state only; there is no combinational path from `three_rready_i`.
- Head presentation: `three_r_o[k]` = head data. `three_rvalid_o[k]` = head valid && pending[k].
- Per-replica handshake: `three_rvalid_o[k] && three_rready_i[k]` clears pending[k]. Any subset of replicas may hand-shake in the same cycle.
- Pop: the head is popped at the clock edge where its mask becomes 0 after that cycle's handshakes.
- Stall counter `cnt`, width `$clog2(TimeoutCycles+1)`:
  - A stall cycle is one where the registered head mask is partial (not 000, not 111) and the cycle's handshakes do not empty it.
  - `cnt` increments on each stall cycle.
  - `cnt` clears on any pop, and holds 0 while the mask is 111.
- Timeout: a stall cycle in which `cnt == TimeoutCycles-1` pops the head at that edge. The next cycle `fault_o`=1 and `fault_mask_o` = the mask remaining at the drop.
- Completion wins: if the last pending replica accepts in the cycle that would have timed out, the pop is normal and no fault is raised.
- With the head fully pending (mask 111, all replicas back-pressuring), this is ordinary backpressure. No timeout applies.
- Push and pop in the same cycle are both performed. Occupancy is unchanged. When full, the pop frees the slot only for the following cycle.
- The buffer is order-preserving. Data is not inspected, voted or ECC-checked.

## Timing
- Reset values: all `three_rvalid_o` 0, `rready_o` 1, `fault_o` 0, `fault_mask_o` 0. Pointers, count and `cnt` are 0. `three_r_o` is don't-care.
- Latency: push at edge t gives `three_rvalid_o` high in cycle t+1 (no fall-through).
- Throughput: one response per cycle when all replicas are always ready and `Depth` ≥ 2. With `Depth`=1 the rate is one response per 2 cycles.
- Wrap-around: pointers wrap modulo `Depth`. Full/empty is tracked by an occupancy count in 0..`Depth`.
- Reset mid-operation: asynchronous clear. Buffered responses are lost, valids drop immediately, and no fault is reported.
- `fault_o` and `fault_mask_o` are registered and never assert in consecutive cycles for the same entry.

## Test plan
- Lock-step, `Depth`=2, replicas always ready, 8 back-to-back pushes with rid 0..7 → each replica sees rid 0..7 in order, one per cycle, starting 1 cycle after the first push; `rready_o` stays 1.
- Skewed acceptance → head popped exactly once, next entry presented the cycle after; no fault.
  - Head rid=3.
  - Replica 0 accepts in cycle 1, replica 2 in cycle 3, replica 1 in cycle 5.
- Timeout with `TimeoutCycles`=4: replicas 0 and 1 accept rid=5 in cycle 1, replica 2 is never ready → entry dropped at end of cycle 5, `fault_o`=1 and `fault_mask_o`=3'b100 in cycle 6, rid=6 valid to all three in cycle 6.
- Completion on the timeout cycle: same setup, but replica 2 accepts in cycle 5 → normal pop, `fault_o` stays 0.
- Full buffer with `Depth`=2: all replicas not ready, 3 pushes offered → `rready_o` drops after 2 accepted and rises the cycle after the head fully pops. No stall counting while the mask is 111.
- Async reset asserted mid-cycle with 2 entries buffered and the head partial → `three_rvalid_o`=000 and `rready_o`=1 immediately; after release, a new push rid=9 is delivered to all three with no fault.

Source files
------------

// File: rtl/relobi_tmr_r_splitter.sv
// Response-side TMR splitter: buffers subordinate R responses and fans each one out
// to three manager replicas, holding it until all replicas handshake or a skew timeout drops it.
module relobi_tmr_r_splitter #(
    parameter ObiCfg = 0,
    parameter type obi_r_chan_t = logic,
    parameter int unsigned Depth = 2,
    parameter int unsigned TimeoutCycles = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  obi_r_chan_t       r_i,
    input  logic              rvalid_i,
    output logic              rready_o,
    output obi_r_chan_t [2:0] three_r_o,
    output logic [2:0]        three_rvalid_o,
    input  logic [2:0]        three_rready_i,
    output logic              fault_o,
    output logic [2:0]        fault_mask_o
);

    localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned OW = $clog2(Depth + 1);
    localparam int unsigned CW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [AW-1:0] LastPtr = AW'(Depth - 1);
    localparam logic [OW-1:0] FullCount = OW'(Depth);
    localparam logic [CW-1:0] CntLast = CW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

    obi_r_chan_t   mem [Depth];
    logic [2:0]    pending [Depth];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [OW-1:0] count;
    logic [CW-1:0] cnt;

    logic          head_valid;
    logic [2:0]    head_mask;
    logic [2:0]    handshake;
    logic [2:0]    mask_left;
    logic          done;
    logic          partial;
    logic          stall;
    logic          timeout;
    logic          pop;
    logic          push;

    always_comb begin
        head_valid = (count != '0);
        head_mask  = pending[rd_ptr];
        handshake  = three_rvalid_o & three_rready_i;
        mask_left  = head_mask & ~handshake;
        done       = head_valid && (mask_left == 3'b000);
        // Fully pending head is plain backpressure; only a partial head is a skew stall.
        partial    = head_valid && (head_mask != 3'b111) && (head_mask != 3'b000);
        stall      = partial && !done;
        timeout    = (TimeoutCycles != 0) && stall && (cnt == CntLast);
        pop        = done || timeout;
        push       = rvalid_i && rready_o;
    end

    assign rready_o       = (count != FullCount);
    assign three_rvalid_o = head_valid ? head_mask : 3'b000;

    always_comb begin
        for (int unsigned k = 0; k < 3; k++) begin
            three_r_o[k] = mem[rd_ptr];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= r_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                pending[i] <= '0;
            end
        end else begin
            if (head_valid) begin
                pending[rd_ptr] <= mask_left;
            end
            if (push) begin
                pending[wr_ptr] <= 3'b111;
                wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + OW'(1);
                2'b01:   count <= count - OW'(1);
                default: count <= count;
            endcase
            if (pop || !partial) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fault_o      <= 1'b0;
            fault_mask_o <= '0;
        end else begin
            fault_o      <= timeout;
            fault_mask_o <= timeout ? mask_left : 3'b000;
        end
    end

endmodule

// File: tb/tb_relobi_tmr_r_splitter.sv
// Directed bench for relobi_tmr_r_splitter (Depth=2, TimeoutCycles=4, 8-bit rid payload).
module tb_relobi_tmr_r_splitter;

    logic             clk;
    logic             rst_n;
    logic [7:0]       r;
    logic             rvalid;
    logic             rready;
    logic [2:0][7:0]  three_r;
    logic [2:0]       three_rvalid;
    logic [2:0]       three_rready;
    logic             fault;
    logic [2:0]       fault_mask;

    int compared   = 0;
    int mismatched = 0;

    relobi_tmr_r_splitter #(
        .obi_r_chan_t (logic [7:0]),
        .Depth        (2),
        .TimeoutCycles(4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .r_i           (r),
        .rvalid_i      (rvalid),
        .rready_o      (rready),
        .three_r_o     (three_r),
        .three_rvalid_o(three_rvalid),
        .three_rready_i(three_rready),
        .fault_o       (fault),
        .fault_mask_o  (fault_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks valids, fault pair, and (when any valid) the rid on all three replicas.
    task automatic chk_state(input string tag, input logic [2:0] vmask, input logic [7:0] rid,
                             input logic exp_fault, input logic [2:0] exp_fmask);
        chk({tag, ".rvalid"}, 32'(three_rvalid), 32'(vmask));
        chk({tag, ".fault"}, 32'(fault), 32'(exp_fault));
        chk({tag, ".fmask"}, 32'(fault_mask), 32'(exp_fmask));
        if (vmask != 3'b000) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("%s.rid%0d", tag, k), 32'(three_r[k]), 32'(rid));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        r = '0;
        rvalid = 1'b0;
        three_rready = 3'b000;
        #2;
        chk("rst.rvalid", 32'(three_rvalid), 32'(3'b000));
        chk("rst.rready", 32'(rready), 32'd1);
        chk("rst.fault", 32'(fault), 32'd0);
        chk("rst.fmask", 32'(fault_mask), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Lock-step streaming, replicas always ready.
        three_rready = 3'b111;
        for (int i = 0; i < 10; i++) begin
            if (i >= 1 && i <= 8) chk_state($sformatf("ls%0d", i), 3'b111, 8'(i - 1), 1'b0, 3'b000);
            if (i == 9) chk_state("ls_empty", 3'b000, 8'h00, 1'b0, 3'b000);
            chk($sformatf("ls%0d.rready", i), 32'(rready), 32'd1);
            rvalid = (i < 8);
            r = 8'(i);
            tick();
        end

        // Skewed acceptance: r0 in cycle 1, r2 in cycle 3, r1 in cycle 5.
        three_rready = 3'b000;
        rvalid = 1'b1; r = 8'd3;
        tick();
        chk_state("sk1", 3'b111, 8'd3, 1'b0, 3'b000);
        r = 8'd4; three_rready = 3'b001;
        tick();
        rvalid = 1'b0;
        chk_state("sk2", 3'b110, 8'd3, 1'b0, 3'b000);
        three_rready = 3'b000;
        tick();
        chk_state("sk3", 3'b110, 8'd3, 1'b0, 3'b000);
        three_rready = 3'b100;
        tick();
        chk_state("sk4", 3'b010, 8'd3, 1'b0, 3'b000);
        three_rready = 3'b000;
        tick();
        chk_state("sk5", 3'b010, 8'd3, 1'b0, 3'b000);
        three_rready = 3'b010;
        tick();
        chk_state("sk6", 3'b111, 8'd4, 1'b0, 3'b000);
        three_rready = 3'b111;
        tick();
        chk_state("sk7", 3'b000, 8'd0, 1'b0, 3'b000);

        // Timeout: replica 2 never ready for rid 5.
        three_rready = 3'b000;
        rvalid = 1'b1; r = 8'd5;
        tick();
        chk_state("to1", 3'b111, 8'd5, 1'b0, 3'b000);
        r = 8'd6; three_rready = 3'b011;
        tick();
        rvalid = 1'b0; three_rready = 3'b000;
        for (int c = 2; c <= 5; c++) begin
            chk_state($sformatf("to%0d", c), 3'b100, 8'd5, 1'b0, 3'b000);
            tick();
        end
        chk_state("to6", 3'b111, 8'd6, 1'b1, 3'b100);
        three_rready = 3'b111;
        tick();
        chk_state("to7", 3'b000, 8'd0, 1'b0, 3'b000);

        // Completion in the cycle that would have timed out.
        three_rready = 3'b000;
        rvalid = 1'b1; r = 8'd7;
        tick();
        chk_state("cp1", 3'b111, 8'd7, 1'b0, 3'b000);
        r = 8'd8; three_rready = 3'b011;
        tick();
        rvalid = 1'b0; three_rready = 3'b000;
        for (int c = 2; c <= 5; c++) begin
            chk_state($sformatf("cp%0d", c), 3'b100, 8'd7, 1'b0, 3'b000);
            if (c == 5) three_rready = 3'b100;
            tick();
        end
        chk_state("cp6", 3'b111, 8'd8, 1'b0, 3'b000);
        three_rready = 3'b111;
        tick();
        chk_state("cp7", 3'b000, 8'd0, 1'b0, 3'b000);

        // Full buffer: 3 pushes offered, nobody ready.
        three_rready = 3'b000;
        rvalid = 1'b1; r = 8'd10;
        chk("fb0.rready", 32'(rready), 32'd1);
        tick();
        chk("fb1.rready", 32'(rready), 32'd1);
        chk_state("fb1", 3'b111, 8'd10, 1'b0, 3'b000);
        r = 8'd11;
        tick();
        r = 8'd12;
        for (int c = 2; c < 9; c++) begin
            chk($sformatf("fb%0d.rready", c), 32'(rready), 32'd0);
            chk_state($sformatf("fb%0d", c), 3'b111, 8'd10, 1'b0, 3'b000);
            tick();
        end
        three_rready = 3'b111;
        chk("fb_pop.rready", 32'(rready), 32'd0);
        tick();
        chk("fb_rise.rready", 32'(rready), 32'd1);
        chk_state("fb_rise", 3'b111, 8'd11, 1'b0, 3'b000);
        tick();
        rvalid = 1'b0;
        chk("fb_last.rready", 32'(rready), 32'd1);
        chk_state("fb_last", 3'b111, 8'd12, 1'b0, 3'b000);
        tick();
        chk_state("fb_empty", 3'b000, 8'd0, 1'b0, 3'b000);

        // Async reset mid-cycle with two entries and a partial head.
        three_rready = 3'b000;
        rvalid = 1'b1; r = 8'd20;
        tick();
        r = 8'd21; three_rready = 3'b001;
        tick();
        rvalid = 1'b0; three_rready = 3'b000;
        chk_state("ar_pre", 3'b110, 8'd20, 1'b0, 3'b000);
        chk("ar_pre.rready", 32'(rready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar.rvalid", 32'(three_rvalid), 32'(3'b000));
        chk("ar.rready", 32'(rready), 32'd1);
        chk("ar.fault", 32'(fault), 32'd0);
        #3 rst_n = 1'b1;
        tick();
        three_rready = 3'b111;
        rvalid = 1'b1; r = 8'd9;
        tick();
        rvalid = 1'b0;
        chk_state("ar_new", 3'b111, 8'd9, 1'b0, 3'b000);
        tick();
        chk_state("ar_done", 3'b000, 8'd0, 1'b0, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
